enemy_fire_scheduler: RTL
=========================

# enemy_fire_scheduler

Schedules enemy return fire for the shooter datapath. It picks one alive enemy per firing opportunity using round-robin order, and allocates a bullet from a shared pool of enemy-bullet slots. It moves active slots down the screen once per frame and frees slots on hit or when they leave the screen. It sits beside the enemy and player-bullet controllers in the clk25 domain, and its slot outputs feed the 8x8 sprite renderers and the player collision logic.

## Interface
- ENEMY_COUNT, 17, number of enemy sources (≤ 32)
- SLOT_COUNT, 4, enemy-bullet pool size
- FIRE_PERIOD, 30, frames between launches (≥ 1)
- BULLET_SPEED, 2, pixels added to y per frame
- SCREEN_H, 480, visible height; y ≥ SCREEN_H is off-screen
- clk25  in  1  pixel clock, the single clock
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- enable  in  1  firing permitted; low forces IDLE
- enemy_alive  in  ENEMY_COUNT  per-enemy alive flags
- enemy_x_flat, enemy_y_flat  in  10*ENEMY_COUNT each  enemy top-left; enemy i occupies bits [10i+9:10i]
- slot_hit  in  SLOT_COUNT  per-slot clear request from collision logic
- ebullet_x_flat, ebullet_y_flat  out  10*SLOT_COUNT each  slot top-left, same packing
- ebullet_active  out  SLOT_COUNT  slot holds a live bullet
- fire_pulse  out  1  one-cycle strobe when a launch takes effect
- fire_idx  out  5  enemy index of the most recent launch

## Operation
- Reset values:
  - All ebullet_x/y = 0; ebullet_active = 0; fire_pulse = 0; fire_idx = 0.
  - State = IDLE; cooldown = FIRE_PERIOD−1.
  - last_fired = ENEMY_COUNT−1, so the first scan starts at enemy 0.
- State IDLE:
  - Holds cooldown at FIRE_PERIOD−1.
  - Goes to WAIT when enable = 1.
- State WAIT:
  - On each frame_tick, cooldown decrements if nonzero.
  - On a frame_tick with cooldown = 0, goes to SCAN with ptr = (last_fired+1) mod ENEMY_COUNT and scanned = 0.
- State SCAN: evaluates one enemy per cycle.
  - Enemy ptr is eligible when enemy_alive[ptr] = 1, at least one slot is free, and enemy_y+32 < SCREEN_H (11-bit compare).
  - Eligible → LAUNCH.
  - Otherwise ptr advances with wrap at ENEMY_COUNT−1 → 0, and scanned increments.
  - When scanned reaches ENEMY_COUNT, goes to WAIT with cooldown = 0, so it retries on the next frame_tick.
- State LAUNCH (one cycle):
  - Targets the lowest-index free slot s.
  - Slot s gets x = enemy_x[ptr]+12 (10-bit, truncating) and y = enemy_y[ptr]+32; active = 1.
  - Also sets fire_idx = ptr, last_fired = ptr, fire_pulse = 1, cooldown = FIRE_PERIOD−1.
  - Goes to WAIT.
- enable = 0 in any state:
  - Forces IDLE on the next edge and aborts any SCAN or LAUNCH in progress, so no launch occurs.
  - Slot motion and clearing continue.
- Slot motion, on frame_tick, for each active slot:
  - If y+BULLET_SPEED ≥ SCREEN_H (11-bit sum), active clears.
  - Else y += BULLET_SPEED.
  - x never changes.
- slot_hit[k] = 1 clears active[k] next edge. slot_hit on an inactive slot is ignored.
- Per-slot priority, same cycle: LAUNCH write > slot_hit > frame_tick motion.
  - A newly launched slot is not moved on its launch edge.
- Inactive slots retain their last x/y (don't-care for consumers).

## Timing
- All outputs are registered. fire_pulse is high exactly one cycle, coincident with the first cycle ebullet_active[s] reads 1.
- Launch latency, for a frame_tick at cycle T with cooldown = 0 and k ineligible enemies skipped:
  - SCAN occupies T+1 … T+1+k.
  - LAUNCH occurs at T+2+k.
  - Outputs change at T+3+k.
- Worst-case scan is ENEMY_COUNT cycles, far shorter than a frame.
- A frame_tick during SCAN or LAUNCH moves slots but does not alter FSM sequencing.
- Launches are spaced at least FIRE_PERIOD frame_ticks apart.
- rst_n assertion mid-operation clears all state immediately (asynchronous). Operation resumes on the first clk25 edge after deassertion.

## Test plan
- Reset, enable = 1, all alive, enemy0 at (100,50), FIRE_PERIOD = 2. Drive frame_ticks → first launch after the 2nd tick: fire_idx = 0, slot0 = (112,82), active = 0001, fire_pulse high 1 cycle, 3 cycles after that tick.
- Continue with all alive → fire_idx sequence 1, 2, …, 16, 0 (wrap), one launch every 2 frame_ticks, into the lowest free slot each time.
- Only enemy 16 alive, last_fired = 0 → 15 skipped SCAN cycles, fire_pulse at T+18, fire_idx = 16.
- SLOT_COUNT = 4, all slots active and no hits → no launch, FSM returns to WAIT. Then slot_hit = 0100 → next eligible launch fills slot2.
- Slot at y = 478, BULLET_SPEED = 2, frame_tick → active clears. Slot at y = 100 with frame_tick and slot_hit in the same cycle → cleared, y unchanged.
- Assert rst_n low during LAUNCH → all outputs 0 immediately, no fire_pulse. Drop enable during SCAN → IDLE, no launch, existing slots keep moving.

Source files
------------

// File: rtl/enemy_fire_scheduler.sv
// Enemy return-fire scheduler: round-robin shooter selection, shared bullet-slot
// pool, per-frame bullet motion and slot clearing on hit or screen exit.
module enemy_fire_scheduler #(
  parameter int ENEMY_COUNT  = 17,
  parameter int SLOT_COUNT   = 4,
  parameter int FIRE_PERIOD  = 30,
  parameter int BULLET_SPEED = 2,
  parameter int SCREEN_H     = 480
) (
  input  logic                     clk25,
  input  logic                     rst_n,
  input  logic                     frame_tick,
  input  logic                     enable,
  input  logic [ENEMY_COUNT-1:0]   enemy_alive,
  input  logic [10*ENEMY_COUNT-1:0] enemy_x_flat,
  input  logic [10*ENEMY_COUNT-1:0] enemy_y_flat,
  input  logic [SLOT_COUNT-1:0]    slot_hit,
  output logic [10*SLOT_COUNT-1:0] ebullet_x_flat,
  output logic [10*SLOT_COUNT-1:0] ebullet_y_flat,
  output logic [SLOT_COUNT-1:0]    ebullet_active,
  output logic                     fire_pulse,
  output logic [4:0]               fire_idx
);

  localparam int CW = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
  localparam int SW = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;
  localparam logic [CW-1:0] CD_RELOAD  = CW'(FIRE_PERIOD - 1);
  localparam logic [4:0]    LAST_IDX   = 5'(ENEMY_COUNT - 1);
  localparam logic [5:0]    SCAN_LAST  = 6'(ENEMY_COUNT - 1);
  localparam logic [10:0]   SCREEN_H11 = 11'(SCREEN_H);
  localparam logic [10:0]   SPEED11    = 11'(BULLET_SPEED);

  typedef enum logic [1:0] {IDLE, WAIT, SCAN, LAUNCH} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cooldown_q, cooldown_d;
  logic [4:0]                   last_q, last_d;
  logic [4:0]                   ptr_q, ptr_d;
  logic [4:0]                   idx_q, idx_d;
  logic [5:0]                   scanned_q, scanned_d;
  logic                         pulse_q, pulse_d;
  logic [SLOT_COUNT-1:0][9:0]   x_q, x_d;
  logic [SLOT_COUNT-1:0][9:0]   y_q, y_d;
  logic [SLOT_COUNT-1:0]        act_q, act_d;

  logic [9:0]    cur_x, cur_y;
  logic          cur_alive;
  logic          any_free;
  logic [SW-1:0] free_slot;
  logic          eligible;
  logic          launch;
  logic [4:0]    ptr_next;

  // Enemy selected by the scan pointer.
  always_comb begin
    cur_x     = '0;
    cur_y     = '0;
    cur_alive = 1'b0;
    for (int unsigned i = 0; i < ENEMY_COUNT; i++) begin
      if (ptr_q == 5'(i)) begin
        cur_x     = enemy_x_flat[10*i +: 10];
        cur_y     = enemy_y_flat[10*i +: 10];
        cur_alive = enemy_alive[i];
      end
    end
  end

  always_comb begin
    any_free  = 1'b0;
    free_slot = '0;
    for (int unsigned s = 0; s < SLOT_COUNT; s++) begin
      if (!act_q[s] && !any_free) begin
        any_free  = 1'b1;
        free_slot = SW'(s);
      end
    end
  end

  assign eligible = cur_alive && any_free && (({1'b0, cur_y} + 11'd32) < SCREEN_H11);
  assign launch   = (state_q == LAUNCH) && enable && any_free;
  assign ptr_next = (ptr_q == LAST_IDX) ? '0 : ptr_q + 5'd1;

  always_comb begin
    state_d    = state_q;
    cooldown_d = cooldown_q;
    last_d     = last_q;
    ptr_d      = ptr_q;
    scanned_d  = scanned_q;
    idx_d      = idx_q;
    pulse_d    = 1'b0;
    if (state_q == IDLE) cooldown_d = CD_RELOAD;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: begin
          if (frame_tick) begin
            if (cooldown_q != '0) begin
              cooldown_d = cooldown_q - 1'b1;
            end else begin
              state_d   = SCAN;
              ptr_d     = (last_q == LAST_IDX) ? '0 : last_q + 5'd1;
              scanned_d = '0;
            end
          end
        end
        SCAN: begin
          if (eligible) begin
            state_d = LAUNCH;
          end else begin
            ptr_d     = ptr_next;
            scanned_d = scanned_q + 6'd1;
            // Full lap without a shooter: retry on the very next frame.
            if (scanned_q == SCAN_LAST) begin
              state_d    = WAIT;
              cooldown_d = '0;
            end
          end
        end
        LAUNCH: begin
          state_d = WAIT;
          if (any_free) begin
            idx_d      = ptr_q;
            last_d     = ptr_q;
            pulse_d    = 1'b1;
            cooldown_d = CD_RELOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Per-slot priority: launch write, then hit, then frame motion.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    act_d = act_q;
    for (int unsigned s = 0; s < SLOT_COUNT; s++) begin
      if (launch && (free_slot == SW'(s))) begin
        x_d[s]   = cur_x + 10'd12;
        y_d[s]   = cur_y + 10'd32;
        act_d[s] = 1'b1;
      end else if (slot_hit[s]) begin
        act_d[s] = 1'b0;
      end else if (frame_tick && act_q[s]) begin
        if (({1'b0, y_q[s]} + SPEED11) >= SCREEN_H11) act_d[s] = 1'b0;
        else                                          y_d[s]   = y_q[s] + SPEED11[9:0];
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cooldown_q <= CD_RELOAD;
      last_q     <= LAST_IDX;
      ptr_q      <= '0;
      idx_q      <= '0;
      scanned_q  <= '0;
      pulse_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      act_q      <= '0;
    end else begin
      state_q    <= state_d;
      cooldown_q <= cooldown_d;
      last_q     <= last_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      scanned_q  <= scanned_d;
      pulse_q    <= pulse_d;
      x_q        <= x_d;
      y_q        <= y_d;
      act_q      <= act_d;
    end
  end

  assign ebullet_x_flat = x_q;
  assign ebullet_y_flat = y_q;
  assign ebullet_active = act_q;
  assign fire_pulse     = pulse_q;
  assign fire_idx       = idx_q;

endmodule
